// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: add/sub mode encoding, the per-stage
// control bundle and the full-adder cell that each slice is built from.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctl_t;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One C-bit slice of the pipelined adder: a ripple chain of full-adder cells plus the
// registers that carry the slice's carry, mode, valid bit and operand/result skew forward.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int C     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic             prev_sub,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    input  logic [WIDTH-1:0] prev_s,
    output logic             valid,
    output logic             sub,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] s
);

    stage_ctl_t         ctl;
    logic [C-1:0]       b_eff;
    logic [C-1:0]       sum;
    logic [C:0]         cy;
    logic [WIDTH+C-1:0] s_ext;

    // Operands arrive shifted so this slice always works on the low C bits.
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        b_eff = prev_b[C-1:0] ^ {C{prev_sub}};
        sum   = '0;
        cy    = '0;
        cy[0] = prev_carry;
        for (int i = 0; i < C; i++) begin
            {cy[i+1], sum[i]} = full_adder(prev_a[i], b_eff[i], cy[i]);
        end
        s_ext = {sum, prev_s};
    end

    // NOTE: sequential state uses non-blocking assignments only, so stage-to-stage transfer is order independent.
    // NOTE: datapath registers are reset as well, so s never shows X after reset even under a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl <= '0;
            ovf <= 1'b0;
            opa <= '0;
            opb <= '0;
            s   <= '0;
        end else if (adv) begin
            ctl <= '{valid: prev_valid, sub: prev_sub, carry: cy[C]};
            ovf <= cy[C] ^ cy[C-1];
            opa <= prev_a >> C;
            opb <= prev_b >> C;
            // Finished chunk enters at the top; after STAGES slices the result is aligned.
            s   <= s_ext[WIDTH+C-1:C];
        end
    end

    assign valid = ctl.valid;
    assign sub   = ctl.sub;
    assign carry = ctl.carry;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained, registered slices with valid/ready
// handshakes. Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic [STAGES:0]   valid_p;
    logic [STAGES:0]   sub_p;
    logic [STAGES:0]   carry_p;
    logic [STAGES-1:0] ovf_p;
    logic [WIDTH-1:0]  a_p [STAGES+1];
    logic [WIDTH-1:0]  b_p [STAGES+1];
    logic [WIDTH-1:0]  s_p [STAGES+1];
    logic              adv;
    logic              unused_bits;

    // The whole pipe moves as one: any slot can advance iff the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign valid_p[0] = in_valid;
    assign sub_p[0]   = sub;
    assign carry_p[0] = (sub == SUB);
    assign a_p[0]     = a;
    assign b_p[0]     = b;
    assign s_p[0]     = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .C     (C)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv        (adv),
            .prev_valid (valid_p[k]),
            .prev_sub   (sub_p[k]),
            .prev_carry (carry_p[k]),
            .prev_a     (a_p[k]),
            .prev_b     (b_p[k]),
            .prev_s     (s_p[k]),
            .valid      (valid_p[k+1]),
            .sub        (sub_p[k+1]),
            .carry      (carry_p[k+1]),
            .ovf        (ovf_p[k]),
            .opa        (a_p[k+1]),
            .opb        (b_p[k+1]),
            .s          (s_p[k+1])
        );
    end

    assign out_valid = valid_p[STAGES];
    assign s         = {carry_p[STAGES], s_p[STAGES]};

`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf = ovf_p[STAGES-1];
`endif

    // Final-slot operand skew, mode bit and inner-slice overflow flags have no consumer.
    assign unused_bits = ^{sub_p[STAGES], a_p[STAGES], b_p[STAGES], ovf_p};

endmodule
